// File: rtl/hilbert_transformer_mc_pkg.sv
// Shared definitions for the multi-channel Hilbert transformer.
//   state_e     : controller FSM states
//   prod_width  : width of a NUM_BITS x NUM_BITS signed product
//   acc_width   : accumulator width with headroom for COEFF_LENGTH additions
package hilbert_transformer_mc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StRound,
        StOut
    } state_e;

    function automatic int unsigned prod_width(input int unsigned num_bits);
        return 2 * num_bits;
    endfunction

    function automatic int unsigned acc_width(input int unsigned num_bits,
                                              input int unsigned coeff_length);
        return 2 * num_bits + $clog2(coeff_length);
    endfunction

endpackage

// File: rtl/hilbert_mac.sv
// Single signed multiply-accumulate with clear, enable and round/saturate.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   clear_i        : zero the accumulator (wins over en_i)
//   en_i           : accumulate sample_i * coeff_i
//   sample_i       : signed sample
//   coeff_i        : signed Q1.(NUM_BITS-1) coefficient
//   result_o       : accumulator >>> (NUM_BITS-1), saturated to NUM_BITS
module hilbert_mac
    import hilbert_transformer_mc_pkg::*;
#(
    parameter int unsigned NUM_BITS     = 24,
    parameter int unsigned COEFF_LENGTH = 13
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clear_i,
    input  logic                en_i,
    input  logic [NUM_BITS-1:0] sample_i,
    input  logic [NUM_BITS-1:0] coeff_i,
    output logic [NUM_BITS-1:0] result_o
);

    localparam int unsigned PW = prod_width(NUM_BITS);
    localparam int unsigned AW = acc_width(NUM_BITS, COEFF_LENGTH);

    logic signed [PW-1:0]       sample_ext;
    logic signed [PW-1:0]       coeff_ext;
    logic signed [PW-1:0]       prod;
    logic signed [AW-1:0]       acc_q;
    logic signed [AW-1:0]       shifted;
    logic [AW-NUM_BITS:0]       upper;

    assign sample_ext = PW'($signed(sample_i));
    assign coeff_ext  = PW'($signed(coeff_i));
    assign prod       = sample_ext * coeff_ext;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + AW'(prod);
        end
    end

    // The shifted value fits NUM_BITS only if every bit above the result's
    // sign bit is a copy of it; otherwise clamp toward the accumulator sign.
    assign shifted = acc_q >>> (NUM_BITS - 1);
    assign upper   = shifted[AW-1:NUM_BITS-1];

    always_comb begin
        result_o = shifted[NUM_BITS-1:0];
        if (!((upper == '0) || (upper == '1))) begin
            if (shifted[AW-1]) begin
                result_o = {1'b1, {(NUM_BITS-1){1'b0}}};
            end else begin
                result_o = {1'b0, {(NUM_BITS-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/hilbert_transformer_mc.sv
// Multi-channel Hilbert transformer: per channel, a Hilbert FIR (cos_o) and a
// matching delay FIR (sin_o), time-multiplexed over one pair of MACs.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   tick_i         : sample strobe; captures signal_i for all channels
//   clear_i        : synchronous clear of overrun_o
//   signal_i       : per-channel input samples
//   ha_coeffs      : Hilbert FIR taps
//   delay_coeffs   : delay FIR taps
//   sin_o, cos_o   : per-channel filtered outputs, held between done_o pulses
//   done_o         : one-cycle pulse when all outputs update
//   busy_o         : computation in progress
//   overrun_o      : sticky, tick seen while busy
module hilbert_transformer_mc
    import hilbert_transformer_mc_pkg::*;
#(
    parameter int unsigned NUM_BITS     = 24,
    parameter int unsigned COEFF_LENGTH = 13,
    parameter int unsigned NUM_CHANNELS = 4
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     tick_i,
    input  logic                                     clear_i,
    input  logic [NUM_CHANNELS-1:0][NUM_BITS-1:0]    signal_i,
    input  logic [COEFF_LENGTH-1:0][NUM_BITS-1:0]    ha_coeffs,
    input  logic [COEFF_LENGTH-1:0][NUM_BITS-1:0]    delay_coeffs,
    output logic [NUM_CHANNELS-1:0][NUM_BITS-1:0]    sin_o,
    output logic [NUM_CHANNELS-1:0][NUM_BITS-1:0]    cos_o,
    output logic                                     done_o,
    output logic                                     busy_o,
    output logic                                     overrun_o
);

    localparam int unsigned CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned TW = $clog2(COEFF_LENGTH);

    state_e state_q, state_d;

    logic [NUM_CHANNELS-1:0][COEFF_LENGTH-1:0][NUM_BITS-1:0] hist_q;
    logic [NUM_CHANNELS-1:0][NUM_BITS-1:0] stage_sin_q, stage_cos_q;
    logic [NUM_CHANNELS-1:0][NUM_BITS-1:0] out_sin_q, out_cos_q;
    logic [CW-1:0]                         ch_q;
    logic [TW-1:0]                         tap_q;
    logic                                  overrun_q;

    logic                                  accept;
    logic                                  last_tap;
    logic                                  last_ch;
    logic                                  mac_clear;
    logic                                  mac_en;
    logic [NUM_BITS-1:0]                   mac_sample;
    logic [NUM_BITS-1:0]                   sin_res, cos_res;

    assign last_tap = (tap_q == TW'(COEFF_LENGTH - 1));
    assign last_ch  = (ch_q == CW'(NUM_CHANNELS - 1));

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick_i) begin
                    accept  = 1'b1;
                    state_d = StMac;
                end
            end
            StMac: begin
                if (last_tap) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                state_d = last_ch ? StOut : StMac;
            end
            StOut: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulators start each channel from zero: cleared while idle and
    // during the round cycle of the previous channel.
    assign mac_clear  = (state_q == StIdle) || (state_q == StRound);
    assign mac_en     = (state_q == StMac);
    assign mac_sample = hist_q[ch_q][tap_q];

    hilbert_mac #(
        .NUM_BITS     (NUM_BITS),
        .COEFF_LENGTH (COEFF_LENGTH)
    ) u_mac_sin (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (mac_clear),
        .en_i     (mac_en),
        .sample_i (mac_sample),
        .coeff_i  (delay_coeffs[tap_q]),
        .result_o (sin_res)
    );

    hilbert_mac #(
        .NUM_BITS     (NUM_BITS),
        .COEFF_LENGTH (COEFF_LENGTH)
    ) u_mac_cos (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (mac_clear),
        .en_i     (mac_en),
        .sample_i (mac_sample),
        .coeff_i  (ha_coeffs[tap_q]),
        .result_o (cos_res)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hist_q      <= '0;
            tap_q       <= '0;
            ch_q        <= '0;
            stage_sin_q <= '0;
            stage_cos_q <= '0;
            out_sin_q   <= '0;
            out_cos_q   <= '0;
        end else begin
            if (accept) begin
                for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                    hist_q[c] <= {hist_q[c][COEFF_LENGTH-2:0], signal_i[c]};
                end
            end
            if (state_q == StMac) begin
                tap_q <= last_tap ? '0 : tap_q + TW'(1);
            end
            if (state_q == StRound) begin
                stage_sin_q[ch_q] <= sin_res;
                stage_cos_q[ch_q] <= cos_res;
                ch_q              <= last_ch ? '0 : ch_q + CW'(1);
            end
            if (state_q == StOut) begin
                out_sin_q <= stage_sin_q;
                out_cos_q <= stage_cos_q;
            end
        end
    end

    // Setting wins over clearing so a late tick is never lost.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            overrun_q <= 1'b0;
        end else if (tick_i && (state_q != StIdle)) begin
            overrun_q <= 1'b1;
        end else if (clear_i) begin
            overrun_q <= 1'b0;
        end
    end

    // During the done cycle the staging registers drive the outputs directly,
    // so the new results are visible in the same cycle as done_o.
    assign done_o    = (state_q == StOut);
    assign busy_o    = (state_q != StIdle);
    assign overrun_o = overrun_q;
    assign sin_o     = done_o ? stage_sin_q : out_sin_q;
    assign cos_o     = done_o ? stage_cos_q : out_cos_q;

endmodule

// File: tb/tb_hilbert_transformer_mc.sv
module tb_hilbert_transformer_mc;

    localparam int NB = 24;
    localparam int CL = 13;
    localparam int NC = 4;

    typedef logic [NC-1:0][NB-1:0] chvec_t;
    typedef logic [CL-1:0][NB-1:0] cvec_t;
    typedef struct packed {
        chvec_t s;
        chvec_t c;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset_i = 1'b1;
    logic   tick_i = 1'b0;
    logic   clear_i = 1'b0;
    chvec_t signal_i = '0;
    cvec_t  ha_coeffs = '0;
    cvec_t  delay_coeffs = '0;
    chvec_t sin_o, cos_o;
    logic   done_o, busy_o, overrun_o;

    int     n_tests = 0;
    int     n_fail = 0;
    exp_t   sb[$];
    logic signed [NB-1:0] mhist [NC][CL];

    always #5 clk = ~clk;

    hilbert_transformer_mc #(
        .NUM_BITS     (NB),
        .COEFF_LENGTH (CL),
        .NUM_CHANNELS (NC)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .tick_i       (tick_i),
        .clear_i      (clear_i),
        .signal_i     (signal_i),
        .ha_coeffs    (ha_coeffs),
        .delay_coeffs (delay_coeffs),
        .sin_o        (sin_o),
        .cos_o        (cos_o),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o)
    );

    // Golden FIR: floor shift by NB-1, saturate to NB bits.
    function automatic logic [NB-1:0] fir(input int ch, input cvec_t co);
        logic signed [63:0] acc, a, b, sh;
        acc = 0;
        for (int t = 0; t < CL; t++) begin
            a = 64'(mhist[ch][t]);
            b = 64'($signed(co[t]));
            acc = acc + a * b;
        end
        sh = acc >>> (NB - 1);
        if (sh > 64'sd8388607) return 24'h7FFFFF;
        if (sh < -64'sd8388608) return 24'h800000;
        return sh[NB-1:0];
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NC; c++)
            for (int t = 0; t < CL; t++) mhist[c][t] = '0;
        sb.delete();
    endfunction

    task automatic do_reset();
        reset_i = 1'b1;
        tick_i  = 1'b0;
        clear_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
    endtask

    // Waits for idle, drives one tick and records the expected result.
    task automatic send_tick(input chvec_t s);
        int   w;
        exp_t e;
        w = 0;
        while (busy_o && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (busy_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_wait busy_o stuck got=%b exp=0", busy_o);
        end
        tick_i   = 1'b1;
        signal_i = s;
        for (int c = 0; c < NC; c++) begin
            for (int t = CL - 1; t > 0; t--) mhist[c][t] = mhist[c][t-1];
            mhist[c][0] = s[c];
        end
        for (int c = 0; c < NC; c++) begin
            e.s[c] = fir(c, delay_coeffs);
            e.c[c] = fir(c, ha_coeffs);
        end
        sb.push_back(e);
        @(negedge clk);
        tick_i = 1'b0;
    endtask

    // Returns at the negedge inside the done_o cycle; cyc counts cycles since tick.
    task automatic wait_done(input int start, output int cyc, output bit seen);
        cyc = start;
        while (!done_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        seen = done_o;
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout got=%0d cycles exp=57", cyc);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (sin_o !== '0) begin n_fail++; $display("FAIL reset_sin got=%h exp=0", sin_o); end
        n_tests++;
        if (cos_o !== '0) begin n_fail++; $display("FAIL reset_cos got=%h exp=0", cos_o); end
        n_tests++;
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        n_tests++;
        if (overrun_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun_o);
        end
    endtask

    task automatic test_impulse();
        chvec_t s;
        exp_t   e;
        int     cyc;
        bit     seen;
        logic [NB-1:0] want;
        do_reset();
        for (int k = 0; k < CL; k++) begin
            ha_coeffs[k]    = NB'(k * 32'h010000);
            delay_coeffs[k] = NB'((k == 0) ? 32'h400000 : 32'h0);
        end
        for (int k = 0; k < CL; k++) begin
            s = '0;
            if (k == 0) s[0] = 24'h400000;
            send_tick(s);
            wait_done(1, cyc, seen);
            e = sb.pop_front();
            if (seen) begin
                want = NB'(k * 32'h008000);
                n_tests++;
                if (cos_o[0] !== want) begin
                    n_fail++; $display("FAIL impulse_k%0d got=%h exp=%h", k, cos_o[0], want);
                end
                n_tests++;
                if (cos_o[NC-1:1] !== '0) begin
                    n_fail++; $display("FAIL impulse_other k%0d got=%h exp=0", k, cos_o[NC-1:1]);
                end
                n_tests++;
                if (sin_o !== e.s) begin
                    n_fail++; $display("FAIL impulse_sin k%0d got=%h exp=%h", k, sin_o, e.s);
                end
            end
        end
    endtask

    task automatic test_delay();
        chvec_t s, want;
        exp_t   e;
        int     cyc;
        bit     seen;
        do_reset();
        for (int k = 0; k < CL; k++) delay_coeffs[k] = (k == 6) ? 24'h7FFFFF : 24'h0;
        for (int c = 0; c < NC; c++) begin
            s[c]    = 24'h100000;
            want[c] = 24'h0FFFFF;
        end
        for (int n = 0; n < 10; n++) begin
            send_tick(s);
            wait_done(1, cyc, seen);
            e = sb.pop_front();
            if (seen) begin
                n_tests++;
                if (sin_o !== e.s || cos_o !== e.c) begin
                    n_fail++;
                    $display("FAIL delay_sb n%0d got=%h/%h exp=%h/%h", n, sin_o, cos_o, e.s, e.c);
                end
                if (n >= 6) begin
                    n_tests++;
                    if (sin_o !== want) begin
                        n_fail++; $display("FAIL delay_settle n%0d got=%h exp=%h", n, sin_o, want);
                    end
                end
            end
        end
    endtask

    task automatic test_saturation();
        chvec_t s, want;
        exp_t   e;
        int     cyc;
        bit     seen;
        do_reset();
        for (int k = 0; k < CL; k++) begin
            ha_coeffs[k]    = 24'h7FFFFF;
            delay_coeffs[k] = 24'h7FFFFF;
        end
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < NC; c++) begin
                s[c]    = (p == 0) ? 24'h7FFFFF : 24'h800000;
                want[c] = s[c];
            end
            for (int n = 0; n < CL; n++) begin
                send_tick(s);
                wait_done(1, cyc, seen);
                e = sb.pop_front();
                if (seen) begin
                    n_tests++;
                    if (sin_o !== e.s || cos_o !== e.c) begin
                        n_fail++;
                        $display("FAIL sat_sb p%0d n%0d got=%h/%h exp=%h/%h",
                                 p, n, sin_o, cos_o, e.s, e.c);
                    end
                    if (n == CL - 1) begin
                        n_tests++;
                        if (sin_o !== want || cos_o !== want) begin
                            n_fail++;
                            $display("FAIL sat_final p%0d got=%h/%h exp=%h", p, sin_o, cos_o, want);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_latency_overrun();
        chvec_t s;
        exp_t   e;
        int     cyc;
        bit     seen;
        do_reset();
        for (int k = 0; k < CL; k++) begin
            ha_coeffs[k]    = (k == 1) ? 24'h400000 : 24'h0;
            delay_coeffs[k] = (k == 0) ? 24'h400000 : 24'h0;
        end
        for (int c = 0; c < NC; c++) s[c] = NB'(32'h111111 * (c + 1));
        send_tick(s);
        repeat (9) @(negedge clk);
        // Late tick: must be dropped, so it never enters the model history.
        tick_i   = 1'b1;
        signal_i = {NC{24'h3ABCDE}};
        @(negedge clk);
        tick_i = 1'b0;
        wait_done(11, cyc, seen);
        e = sb.pop_front();
        n_tests++;
        if (cyc !== 57) begin n_fail++; $display("FAIL latency got=%0d exp=57", cyc); end
        n_tests++;
        if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL overrun_set got=%b exp=1", overrun_o); end
        if (seen) begin
            n_tests++;
            if (sin_o !== e.s) begin n_fail++; $display("FAIL lat_sin got=%h exp=%h", sin_o, e.s); end
        end
        // Tap 1 of the Hilbert filter now exposes the previous accepted sample.
        for (int c = 0; c < NC; c++) s[c] = NB'(32'h050505 * (c + 1));
        send_tick(s);
        repeat (5) @(negedge clk);
        tick_i  = 1'b1;
        clear_i = 1'b1;
        @(negedge clk);
        tick_i  = 1'b0;
        clear_i = 1'b0;
        n_tests++;
        if (overrun_o !== 1'b1) begin
            n_fail++; $display("FAIL overrun_set_wins got=%b exp=1", overrun_o);
        end
        wait_done(7, cyc, seen);
        e = sb.pop_front();
        if (seen) begin
            n_tests++;
            if (cos_o !== e.c || sin_o !== e.s) begin
                n_fail++; $display("FAIL dropped_sample got=%h/%h exp=%h/%h", sin_o, cos_o, e.s, e.c);
            end
        end
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        n_tests++;
        if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL overrun_clear got=%b exp=0", overrun_o); end
    endtask

    task automatic test_reset_midop();
        chvec_t s;
        exp_t   e;
        int     cyc;
        bit     seen;
        bit     spurious;
        do_reset();
        for (int k = 0; k < CL; k++) begin
            ha_coeffs[k]    = NB'(32'h020000 * (k + 1));
            delay_coeffs[k] = NB'(32'h7FFFFF - 32'h050000 * k);
        end
        for (int c = 0; c < NC; c++) s[c] = NB'(32'h200000 + 32'h010000 * c);
        send_tick(s);
        wait_done(1, cyc, seen);
        sb.delete();
        send_tick(s);
        repeat (19) @(negedge clk);
        reset_i = 1'b1;
        #1;
        n_tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++; $display("FAIL midreset_ctrl got=%b%b exp=00", busy_o, done_o);
        end
        n_tests++;
        if (sin_o !== '0 || cos_o !== '0) begin
            n_fail++; $display("FAIL midreset_out got=%h/%h exp=0", sin_o, cos_o);
        end
        model_reset();
        @(negedge clk);
        reset_i = 1'b0;
        spurious = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (done_o) spurious = 1'b1;
        end
        n_tests++;
        if (spurious !== 1'b0) begin n_fail++; $display("FAIL midreset_nodone got=1 exp=0"); end
        for (int c = 0; c < NC; c++) s[c] = NB'(32'h7654AB - 32'h100000 * c);
        send_tick(s);
        wait_done(1, cyc, seen);
        e = sb.pop_front();
        if (seen) begin
            n_tests++;
            if (sin_o !== e.s || cos_o !== e.c) begin
                n_fail++;
                $display("FAIL post_reset got=%h/%h exp=%h/%h", sin_o, cos_o, e.s, e.c);
            end
        end
    endtask

    task automatic test_channels();
        chvec_t s;
        exp_t   e;
        int     cyc;
        bit     seen;
        real    ph;
        do_reset();
        for (int k = 0; k < CL; k++) begin
            ha_coeffs[k]    = NB'($urandom);
            delay_coeffs[k] = NB'($signed(NB'($urandom)) >>> 2);
        end
        for (int n = 0; n < 16; n++) begin
            for (int c = 0; c < NC; c++) begin
                ph   = 2.0 * 3.14159265358979 * real'((c + 1) * n) / 16.0 + real'(c);
                s[c] = NB'(int'(3145728.0 * $sin(ph)));
            end
            send_tick(s);
            wait_done(1, cyc, seen);
            e = sb.pop_front();
            if (seen) begin
                for (int c = 0; c < NC; c++) begin
                    n_tests++;
                    if (sin_o[c] !== e.s[c] || cos_o[c] !== e.c[c]) begin
                        n_fail++;
                        $display("FAIL chan%0d n%0d got=%h/%h exp=%h/%h",
                                 c, n, sin_o[c], cos_o[c], e.s[c], e.c[c]);
                    end
                end
            end
        end
        // Outputs hold between done pulses.
        repeat (20) @(negedge clk);
        n_tests++;
        if (sin_o !== e.s || cos_o !== e.c) begin
            n_fail++; $display("FAIL hold got=%h/%h exp=%h/%h", sin_o, cos_o, e.s, e.c);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        reset_i = 1'b0;
        @(negedge clk);
        test_impulse();
        test_delay();
        test_saturation();
        test_latency_overrun();
        test_reset_midop();
        test_channels();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
